multdiv_seq: RTL

Iterative signed 32-bit multiply/divide unit. It time-shares a single csa_32 carry-select adder for every add, subtract and negate step under a small FSM. It sits beside the ALU in the execute stage: the processor pulses a start strobe, stalls on `busy`, and captures the result on `data_resultRDY`.

---
 rtl/multdiv_seq_pkg.sv | 45 ++++
 rtl/csa_32.sv | 31 +++
 rtl/multdiv_fsm.sv | 152 +++++++++++++++
 rtl/multdiv_seq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/multdiv_seq_pkg.sv
// rtl/multdiv_seq_pkg.sv - shared types and constants for the iterative multiply/divide unit
package multdiv_seq_pkg;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_MUL_IT    = 3'd1;
    localparam logic [2:0] ST_DIV_ABS_A = 3'd2;
    localparam logic [2:0] ST_DIV_ABS_B = 3'd3;
    localparam logic [2:0] ST_DIV_IT    = 3'd4;
    localparam logic [2:0] ST_DIV_FIX   = 3'd5;
    localparam logic [2:0] ST_DONE      = 3'd6;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        MUL_IT    = ST_MUL_IT,
        DIV_ABS_A = ST_DIV_ABS_A,
        DIV_ABS_B = ST_DIV_ABS_B,
        DIV_IT    = ST_DIV_IT,
        DIV_FIX   = ST_DIV_FIX,
        DONE      = ST_DONE
    } state_t;

    // Last value of the 6-bit iteration counter (32 iterations: 0..31)
    localparam logic [5:0] ITER_LAST = 6'd31;

    // Cycles from accepted start to the RDY cycle
    localparam int MUL_LAT = 33;
    localparam int DIV_LAT = 36;
    localparam int DZ_LAT  = 1;

    // Shared adder operand selects
    typedef enum logic [1:0] {
        A_ZERO = 2'd0,   // constant 0 (negate)
        A_HI   = 2'd1,   // P_hi (Booth accumulate)
        A_RSH  = 2'd2    // {R, Q} shifted left, upper half (restoring trial)
    } a_sel_t;

    typedef enum logic [1:0] {
        B_ZERO   = 2'd0,
        B_M      = 2'd1, // M / |B|
        B_NOT_M  = 2'd2, // ~M, subtract or negate M
        B_NOT_LO = 2'd3  // ~P_lo/Q, negate the low register
    } b_sel_t;

endpackage

// File: rtl/csa_32.sv
// rtl/csa_32.sv - 32-bit carry-select adder with carry-out and signed overflow
//
// Ports:
//   a, b  : addends
//   ci    : carry in
//   sum   : a + b + ci (low 32 bits)
//   co    : carry out of bit 31
//   ovf   : signed overflow of the two's complement add
module csa_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] sum,
    output logic        co,
    output logic        ovf
);

    logic [16:0] lo_s;
    logic [16:0] hi_c0;
    logic [16:0] hi_c1;

    // Upper half is computed for both carry-in values, then selected
    assign lo_s  = {1'b0, a[15:0]} + {1'b0, b[15:0]} + {16'd0, ci};
    assign hi_c0 = {1'b0, a[31:16]} + {1'b0, b[31:16]};
    assign hi_c1 = {1'b0, a[31:16]} + {1'b0, b[31:16]} + 17'd1;

    assign sum[15:0]        = lo_s[15:0];
    assign {co, sum[31:16]} = lo_s[16] ? hi_c1 : hi_c0;
    assign ovf              = (a[31] == b[31]) && (sum[31] != a[31]);

endmodule

// File: rtl/multdiv_fsm.sv
// rtl/multdiv_fsm.sv - sequencing FSM, iteration counter and adder/load control for multdiv_seq
//
// Ports:
//   clock, reset_n            : clock, async active-low reset
//   ctrl_mult, ctrl_div       : start strobes (MULT has priority)
//   b_zero                    : operand B is zero (divide-by-zero check at start)
//   lo_msb, lo_lsb, q_bit     : datapath status (P_lo / dividend sign, Booth pair)
//   m_msb                     : sign of M / divisor register
//   busy, rdy                 : status outputs
//   a_sel, b_sel, ci          : shared adder operand and carry-in selects
//   mul_addsub                : Booth step uses the adder result
//   ld_*                      : datapath register load enables
import multdiv_seq_pkg::*;

module multdiv_fsm (
    input  logic   clock,
    input  logic   reset_n,
    input  logic   ctrl_mult,
    input  logic   ctrl_div,
    input  logic   b_zero,
    input  logic   lo_msb,
    input  logic   lo_lsb,
    input  logic   q_bit,
    input  logic   m_msb,
    output logic   busy,
    output logic   rdy,
    output a_sel_t a_sel,
    output b_sel_t b_sel,
    output logic   ci,
    output logic   mul_addsub,
    output logic   ld_init_mul,
    output logic   ld_init_div,
    output logic   ld_dz,
    output logic   ld_mul_step,
    output logic   ld_mul_res,
    output logic   ld_lo_sum,
    output logic   ld_m_sum,
    output logic   ld_div_step,
    output logic   ld_fix
);

    state_t     state;
    state_t     state_nx;
    logic [5:0] cnt;
    logic       iter_state;
    logic       last;

    assign iter_state = (state == MUL_IT) || (state == DIV_IT);
    assign last       = (cnt == ITER_LAST);
    assign busy       = (state != IDLE);
    assign rdy        = (state == DONE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= 6'd0;
        end else begin
            state <= state_nx;
            // Counter runs only inside the iteration states and rests at 0
            cnt   <= (iter_state && !last) ? cnt + 6'd1 : 6'd0;
        end
    end

    always_comb begin
        state_nx    = state;
        a_sel       = A_ZERO;
        b_sel       = B_ZERO;
        ci          = 1'b0;
        mul_addsub  = 1'b0;
        ld_init_mul = 1'b0;
        ld_init_div = 1'b0;
        ld_dz       = 1'b0;
        ld_mul_step = 1'b0;
        ld_mul_res  = 1'b0;
        ld_lo_sum   = 1'b0;
        ld_m_sum    = 1'b0;
        ld_div_step = 1'b0;
        ld_fix      = 1'b0;

        case (state)
            IDLE: begin
                if (ctrl_mult) begin
                    ld_init_mul = 1'b1;
                    state_nx    = MUL_IT;
                end else if (ctrl_div) begin
                    if (b_zero) begin
                        ld_dz    = 1'b1;
                        state_nx = DONE;
                    end else begin
                        ld_init_div = 1'b1;
                        state_nx    = DIV_ABS_A;
                    end
                end
            end
            MUL_IT: begin
                a_sel       = A_HI;
                ld_mul_step = 1'b1;
                case ({lo_lsb, q_bit})
                    2'b01: begin
                        b_sel      = B_M;
                        mul_addsub = 1'b1;
                    end
                    2'b10: begin
                        b_sel      = B_NOT_M;
                        ci         = 1'b1;
                        mul_addsub = 1'b1;
                    end
                    default: ;
                endcase
                if (last) begin
                    ld_mul_res = 1'b1;
                    state_nx   = DONE;
                end
            end
            DIV_ABS_A: begin
                b_sel     = B_NOT_LO;
                ci        = 1'b1;
                ld_lo_sum = lo_msb;
                state_nx  = DIV_ABS_B;
            end
            DIV_ABS_B: begin
                b_sel    = B_NOT_M;
                ci       = 1'b1;
                ld_m_sum = m_msb;
                state_nx = DIV_IT;
            end
            DIV_IT: begin
                a_sel       = A_RSH;
                b_sel       = B_NOT_M;
                ci          = 1'b1;
                ld_div_step = 1'b1;
                if (last) begin
                    state_nx = DIV_FIX;
                end
            end
            DIV_FIX: begin
                // Adder always presents -Q here; the datapath picks it if the sign is negative
                b_sel    = B_NOT_LO;
                ci       = 1'b1;
                ld_fix   = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/multdiv_seq.sv
// rtl/multdiv_seq.sv - iterative signed 32-bit multiply/divide sharing one carry-select adder
//
// Ports:
//   clock, reset_n   : clock, async active-low reset
//   data_operandA    : multiplicand / dividend (signed), sampled on accepted start
//   data_operandB    : multiplier / divisor (signed), sampled on accepted start
//   ctrl_MULT        : start A*B (wins over ctrl_DIV)
//   ctrl_DIV         : start A/B
//   data_result      : low product word or truncated quotient, held until replaced
//   data_exception   : overflow / divide-by-zero flag, held with the result
//   data_resultRDY   : one-cycle result-valid pulse
//   busy             : operation in progress (through the RDY cycle)
import multdiv_seq_pkg::*;

module multdiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    // m_r: multiplicand or divisor; hi_r: P_hi or remainder R;
    // lo_r: P_lo (multiplier) or dividend shifting into quotient Q
    logic [WIDTH-1:0] m_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             q_r;
    logic             sign_r;

    a_sel_t           a_sel;
    b_sel_t           b_sel;
    logic             ci;
    logic             mul_addsub;
    logic             ld_init_mul;
    logic             ld_init_div;
    logic             ld_dz;
    logic             ld_mul_step;
    logic             ld_mul_res;
    logic             ld_lo_sum;
    logic             ld_m_sum;
    logic             ld_div_step;
    logic             ld_fix;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;

    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] mul_base;
    logic             mul_sign_in;
    logic [WIDTH-1:0] mul_hi_nx;
    logic [WIDTH-1:0] mul_lo_nx;

    multdiv_fsm u_fsm (
        .clock       (clock),
        .reset_n     (reset_n),
        .ctrl_mult   (ctrl_MULT),
        .ctrl_div    (ctrl_DIV),
        .b_zero      (data_operandB == '0),
        .lo_msb      (lo_r[WIDTH-1]),
        .lo_lsb      (lo_r[0]),
        .q_bit       (q_r),
        .m_msb       (m_r[WIDTH-1]),
        .busy        (busy),
        .rdy         (data_resultRDY),
        .a_sel       (a_sel),
        .b_sel       (b_sel),
        .ci          (ci),
        .mul_addsub  (mul_addsub),
        .ld_init_mul (ld_init_mul),
        .ld_init_div (ld_init_div),
        .ld_dz       (ld_dz),
        .ld_mul_step (ld_mul_step),
        .ld_mul_res  (ld_mul_res),
        .ld_lo_sum   (ld_lo_sum),
        .ld_m_sum    (ld_m_sum),
        .ld_div_step (ld_div_step),
        .ld_fix      (ld_fix)
    );

    assign r_shift = {hi_r[WIDTH-2:0], lo_r[WIDTH-1]};

    always_comb begin
        add_a = '0;
        case (a_sel)
            A_HI:    add_a = hi_r;
            A_RSH:   add_a = r_shift;
            default: add_a = '0;
        endcase
    end

    always_comb begin
        add_b = '0;
        case (b_sel)
            B_M:      add_b = m_r;
            B_NOT_M:  add_b = ~m_r;
            B_NOT_LO: add_b = ~lo_r;
            default:  add_b = '0;
        endcase
    end

    csa_32 u_add (
        .a   (add_a),
        .b   (add_b),
        .ci  (ci),
        .sum (sum),
        .co  (co),
        .ovf (ovf)
    );

    // Booth step: the add/sub result is effectively 33 bits wide; sum[31]^ovf
    // recovers its true sign so the arithmetic shift keeps the value exact.
    assign mul_base    = mul_addsub ? sum : hi_r;
    assign mul_sign_in = mul_addsub ? (sum[WIDTH-1] ^ ovf) : hi_r[WIDTH-1];
    assign mul_hi_nx   = {mul_sign_in, mul_base[WIDTH-1:1]};
    assign mul_lo_nx   = {mul_base[0], lo_r[WIDTH-1:1]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_r            <= '0;
            hi_r           <= '0;
            lo_r           <= '0;
            q_r            <= 1'b0;
            sign_r         <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else begin
            if (ld_init_mul) begin
                m_r  <= data_operandA;
                lo_r <= data_operandB;
                hi_r <= '0;
                q_r  <= 1'b0;
            end
            if (ld_init_div) begin
                m_r    <= data_operandB;
                lo_r   <= data_operandA;
                hi_r   <= '0;
                q_r    <= 1'b0;
                sign_r <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            end
            if (ld_dz) begin
                data_result    <= '0;
                data_exception <= 1'b1;
            end
            if (ld_mul_step) begin
                hi_r <= mul_hi_nx;
                lo_r <= mul_lo_nx;
                q_r  <= lo_r[0];
            end
            if (ld_mul_res) begin
                // Product overflows 32 bits unless P_hi is pure sign extension of P_lo
                data_result    <= mul_lo_nx;
                data_exception <= (mul_hi_nx != {WIDTH{mul_lo_nx[WIDTH-1]}});
            end
            if (ld_lo_sum) begin
                lo_r <= sum;
            end
            if (ld_m_sum) begin
                m_r <= sum;
            end
            if (ld_div_step) begin
                // co=1 means no borrow: shifted remainder >= |B|
                hi_r <= co ? sum : r_shift;
                lo_r <= {lo_r[WIDTH-2:0], co};
            end
            if (ld_fix) begin
                // A positive quotient with bit 31 set is only 0x80000000 / -1
                data_result    <= sign_r ? sum : lo_r;
                data_exception <= ~sign_r & lo_r[WIDTH-1];
            end
        end
    end

endmodule
